// File: rtl/hyperbus_cfg_loader.sv
`default_nettype none
// ============================================================================
// Module   : hyperbus_cfg_loader
// Brief    : Boot-time REG_BUS initiator that writes (and optionally reads back
//            and checks) every hyperbus configuration word after a start pulse.
// Revision : 1.0 - initial release
// ============================================================================
module hyperbus_cfg_loader #(
    parameter int          NR_CS     = 2,
    parameter int          VERIFY    = 1,
    parameter int          TIMEOUT   = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0,
    localparam int         NUM_REG   = 6 + 2 * NR_CS,
    localparam int         IDX_W     = $clog2(NUM_REG)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [32*NUM_REG-1:0] cfg_vals_i,
    output logic [31:0]           reg_addr_o,
    output logic                  reg_write_o,
    output logic [31:0]           reg_wdata_o,
    output logic [3:0]            reg_wstrb_o,
    output logic                  reg_valid_o,
    input  logic                  reg_ready_i,
    input  logic [31:0]           reg_rdata_i,
    input  logic                  reg_error_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic [1:0]            err_code_o,
    output logic [IDX_W-1:0]      err_idx_o
);

    localparam int               TO_W      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TO_W-1:0]  C_TO_LAST = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [IDX_W-1:0] C_LAST    = IDX_W'(NUM_REG - 1);

    localparam logic [1:0] C_ERR_NONE = 2'd0;
    localparam logic [1:0] C_ERR_BUS  = 2'd1;
    localparam logic [1:0] C_ERR_CMP  = 2'd2;
    localparam logic [1:0] C_ERR_TO   = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WR   = 3'd1,
        S_RD   = 3'd2,
        S_NEXT = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t           r_state;
    logic [IDX_W-1:0] r_idx;
    logic [TO_W-1:0]  r_to_cnt;

    logic             w_hs;
    logic             w_last;
    logic             w_mismatch;
    logic [1:0]       w_code;
    logic [31:0]      w_mask;
    logic [31:0]      w_word;
    logic [31:0]      w_next_word;
    logic [31:0]      w_next_addr;
    logic [IDX_W-1:0] w_next_idx;

    assign reg_wstrb_o = 4'hF;

    assign w_next_idx  = r_idx + IDX_W'(1);
    assign w_word      = cfg_vals_i[{r_idx, 5'b00000} +: 32];
    assign w_next_word = cfg_vals_i[{w_next_idx, 5'b00000} +: 32];
    assign w_next_addr = BASE_ADDR + {{(30 - IDX_W){1'b0}}, w_next_idx, 2'b00};

    // Only the implemented bits of the timing registers read back; the
    // remaining words are full 32-bit registers.
    always_comb begin
        w_mask = 32'hFFFF_FFFF;
        case (r_idx)
            IDX_W'(0): w_mask = 32'h0000_000F;
            IDX_W'(1): w_mask = 32'h0000_000F;
            IDX_W'(2): w_mask = 32'h0000_00FF;
            IDX_W'(3): w_mask = 32'h0000_000F;
            IDX_W'(4): w_mask = 32'h0000_0007;
            default:   w_mask = 32'hFFFF_FFFF;
        endcase
    end

    always_comb begin
        w_hs       = reg_valid_o & reg_ready_i;
        w_last     = (r_idx == C_LAST);
        w_mismatch = ((reg_rdata_i ^ w_word) & w_mask) != 32'h0;
        w_code     = C_ERR_NONE;
        if (r_state == S_WR || r_state == S_RD) begin
            if (w_hs) begin
                if (reg_error_i) begin
                    w_code = C_ERR_BUS;
                end else if (r_state == S_RD && w_mismatch) begin
                    w_code = C_ERR_CMP;
                end
            end else if (TIMEOUT != 0 && r_to_cnt == C_TO_LAST) begin
                w_code = C_ERR_TO;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_to_cnt    <= '0;
            reg_valid_o <= 1'b0;
            reg_write_o <= 1'b0;
            reg_addr_o  <= BASE_ADDR;
            reg_wdata_o <= 32'h0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            err_o       <= 1'b0;
            err_code_o  <= C_ERR_NONE;
            err_idx_o   <= '0;
        end else begin
            done_o <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_idx       <= '0;
                        r_to_cnt    <= '0;
                        err_o       <= 1'b0;
                        err_code_o  <= C_ERR_NONE;
                        err_idx_o   <= '0;
                        busy_o      <= 1'b1;
                        reg_valid_o <= 1'b1;
                        reg_write_o <= 1'b1;
                        reg_addr_o  <= BASE_ADDR;
                        reg_wdata_o <= cfg_vals_i[31:0];
                        r_state     <= S_WR;
                    end
                end
                S_WR, S_RD: begin
                    if (w_code != C_ERR_NONE) begin
                        // Abort on the first failure: no further transfers.
                        err_o       <= 1'b1;
                        err_code_o  <= w_code;
                        err_idx_o   <= r_idx;
                        reg_valid_o <= 1'b0;
                        done_o      <= 1'b1;
                        r_state     <= S_DONE;
                    end else if (w_hs) begin
                        r_to_cnt <= '0;
                        if (r_state == S_WR && VERIFY != 0) begin
                            reg_write_o <= 1'b0;
                            r_state     <= S_RD;
                        end else begin
                            reg_valid_o <= 1'b0;
                            if (w_last) begin
                                done_o  <= 1'b1;
                                r_state <= S_DONE;
                            end else begin
                                r_state <= S_NEXT;
                            end
                        end
                    end else begin
                        r_to_cnt <= r_to_cnt + TO_W'(1);
                    end
                end
                S_NEXT: begin
                    r_idx       <= w_next_idx;
                    r_to_cnt    <= '0;
                    reg_valid_o <= 1'b1;
                    reg_write_o <= 1'b1;
                    reg_addr_o  <= w_next_addr;
                    reg_wdata_o <= w_next_word;
                    r_state     <= S_WR;
                end
                S_DONE: begin
                    busy_o  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hyperbus_cfg_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_hyperbus_cfg_loader
// Brief    : Directed bench for hyperbus_cfg_loader (write-only and verify DUTs).
// Revision : 1.0 - initial release
// ============================================================================
module tb_hyperbus_cfg_loader;

    localparam logic [31:0] WORDS [10] = '{
        32'h0000_0003, 32'h0000_0005, 32'h0000_0299, 32'h0000_0009, 32'h1234_5676,
        32'h00C0_FFEE, 32'h0000_0000, 32'h00FF_FFFF, 32'h0100_0000, 32'h01FF_FFFF
    };

    logic         clk = 1'b0;
    logic         rst;
    logic [319:0] cfg;

    logic        start_a, ready_a, error_a;
    logic [31:0] rdata_a;
    logic [31:0] addr_a, wdata_a;
    logic [3:0]  wstrb_a, idx_a;
    logic        write_a, valid_a, busy_a, done_a, err_a;
    logic [1:0]  code_a;

    logic        start_b, ready_b, error_b, zero_rd;
    logic [31:0] rdata_b;
    logic [31:0] addr_b, wdata_b;
    logic [3:0]  wstrb_b, idx_b;
    logic        write_b, valid_b, busy_b, done_b, err_b;
    logic [1:0]  code_b;
    logic [31:0] mem_b [16];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    hyperbus_cfg_loader #(.NR_CS(2), .VERIFY(0), .TIMEOUT(16), .BASE_ADDR(32'h0)) u_dut_a (
        .clk_i(clk), .rst_i(rst), .start_i(start_a), .cfg_vals_i(cfg),
        .reg_addr_o(addr_a), .reg_write_o(write_a), .reg_wdata_o(wdata_a), .reg_wstrb_o(wstrb_a),
        .reg_valid_o(valid_a), .reg_ready_i(ready_a), .reg_rdata_i(rdata_a), .reg_error_i(error_a),
        .busy_o(busy_a), .done_o(done_a), .err_o(err_a), .err_code_o(code_a), .err_idx_o(idx_a)
    );

    hyperbus_cfg_loader #(.NR_CS(2), .VERIFY(1), .TIMEOUT(256), .BASE_ADDR(32'h0)) u_dut_b (
        .clk_i(clk), .rst_i(rst), .start_i(start_b), .cfg_vals_i(cfg),
        .reg_addr_o(addr_b), .reg_write_o(write_b), .reg_wdata_o(wdata_b), .reg_wstrb_o(wstrb_b),
        .reg_valid_o(valid_b), .reg_ready_i(ready_b), .reg_rdata_i(rdata_b), .reg_error_i(error_b),
        .busy_o(busy_b), .done_o(done_b), .err_o(err_b), .err_code_o(code_b), .err_idx_o(idx_b)
    );

    // Responder model: a register file that only implements some bits.
    function automatic logic [31:0] hw_mask(input logic [3:0] k);
        case (k)
            4'd0, 4'd1, 4'd3: hw_mask = 32'h0000_000F;
            4'd2:             hw_mask = 32'h0000_00FF;
            4'd4:             hw_mask = 32'h0000_0007;
            default:          hw_mask = 32'hFFFF_FFFF;
        endcase
    endfunction

    always @(posedge clk) begin
        if (valid_b && ready_b && write_b) mem_b[addr_b[5:2]] <= wdata_b & hw_mask(addr_b[5:2]);
    end
    assign rdata_b = (zero_rd && addr_b == 32'h8) ? 32'h0 : mem_b[addr_b[5:2]];

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (valid_a !== 1'b0 || valid_b !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b/%b exp=0", valid_a, valid_b); end
        total++; if (write_a !== 1'b0 || busy_a !== 1'b0 || done_a !== 1'b0) begin bad++; $display("FAIL rst_ctrl got w=%b b=%b d=%b exp=0", write_a, busy_a, done_a); end
        total++; if (addr_a !== 32'h0 || wdata_a !== 32'h0) begin bad++; $display("FAIL rst_addr got=%h/%h exp=0/0", addr_a, wdata_a); end
        total++; if (err_a !== 1'b0 || code_a !== 2'd0 || idx_a !== 4'd0) begin bad++; $display("FAIL rst_err got=%b/%0d/%0d exp=0/0/0", err_a, code_a, idx_a); end
        total++; if (busy_b !== 1'b0 || err_b !== 1'b0 || code_b !== 2'd0) begin bad++; $display("FAIL rst_b got=%b/%b/%0d exp=0", busy_b, err_b, code_b); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_write_seq();
        int k;
        ready_a = 1'b1;
        start_a = 1'b1; @(negedge clk); start_a = 1'b0;
        total++; if (wstrb_a !== 4'hF) begin bad++; $display("FAIL wstrb got=%h exp=f", wstrb_a); end
        for (int c = 1; c <= 20; c++) begin
            k = (c - 1) / 2;
            total++; if (valid_a !== ((c % 2) == 1)) begin bad++; $display("FAIL wseq_valid c=%0d got=%b", c, valid_a); end
            if ((c % 2) == 1) begin
                total++; if (addr_a !== 32'(4 * k) || write_a !== 1'b1) begin bad++; $display("FAIL wseq_addr c=%0d got=%h w=%b exp=%h", c, addr_a, write_a, 4 * k); end
                total++; if (wdata_a !== WORDS[k]) begin bad++; $display("FAIL wseq_wdata c=%0d got=%h exp=%h", c, wdata_a, WORDS[k]); end
            end
            total++; if (done_a !== (c == 20)) begin bad++; $display("FAIL wseq_done c=%0d got=%b", c, done_a); end
            @(negedge clk);
        end
        total++; if (err_a !== 1'b0 || busy_a !== 1'b0) begin bad++; $display("FAIL wseq_end got err=%b busy=%b exp=0/0", err_a, busy_a); end
    endtask

    task automatic test_verify();
        int k;
        ready_b = 1'b1; zero_rd = 1'b0;
        start_b = 1'b1; @(negedge clk); start_b = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            k = (c - 1) / 3;
            total++; if (valid_b !== ((c % 3) != 0 && c < 30)) begin bad++; $display("FAIL ver_valid c=%0d got=%b", c, valid_b); end
            if ((c % 3) != 0 && c < 30) begin
                total++; if (write_b !== ((c % 3) == 1) || addr_b !== 32'(4 * k)) begin bad++; $display("FAIL ver_req c=%0d got w=%b a=%h exp a=%h", c, write_b, addr_b, 4 * k); end
            end
            total++; if (done_b !== (c == 30)) begin bad++; $display("FAIL ver_done c=%0d got=%b", c, done_b); end
            if (c == 30) begin
                total++; if (err_b !== 1'b0 || code_b !== 2'd0) begin bad++; $display("FAIL ver_err got=%b/%0d exp=0/0", err_b, code_b); end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_mismatch();
        zero_rd = 1'b1;
        start_b = 1'b1; @(negedge clk); start_b = 1'b0;
        repeat (7) @(negedge clk);
        total++; if (valid_b !== 1'b1 || write_b !== 1'b0 || addr_b !== 32'h8) begin bad++; $display("FAIL mm_rd got v=%b w=%b a=%h exp 1/0/8", valid_b, write_b, addr_b); end
        @(negedge clk);
        total++; if (done_b !== 1'b1 || err_b !== 1'b1) begin bad++; $display("FAIL mm_done got d=%b e=%b exp 1/1", done_b, err_b); end
        total++; if (code_b !== 2'd2 || idx_b !== 4'd2) begin bad++; $display("FAIL mm_code got=%0d/%0d exp=2/2", code_b, idx_b); end
        for (int c = 9; c <= 14; c++) begin
            total++; if (valid_b !== 1'b0) begin bad++; $display("FAIL mm_abort c=%0d got valid=%b exp=0", c, valid_b); end
            @(negedge clk);
        end
        zero_rd = 1'b0;
    endtask

    task automatic test_bus_error();
        ready_a = 1'b1;
        start_a = 1'b1; @(negedge clk); start_a = 1'b0;
        repeat (14) @(negedge clk);
        total++; if (valid_a !== 1'b1 || addr_a !== 32'h1C || write_a !== 1'b1) begin bad++; $display("FAIL be_req got v=%b a=%h exp 1/1c", valid_a, addr_a); end
        error_a = 1'b1; @(negedge clk); error_a = 1'b0;
        total++; if (done_a !== 1'b1 || valid_a !== 1'b0) begin bad++; $display("FAIL be_done got d=%b v=%b exp 1/0", done_a, valid_a); end
        total++; if (err_a !== 1'b1 || code_a !== 2'd1 || idx_a !== 4'd7) begin bad++; $display("FAIL be_code got=%b/%0d/%0d exp=1/1/7", err_a, code_a, idx_a); end
        repeat (3) @(negedge clk);
        total++; if (valid_a !== 1'b0 || busy_a !== 1'b0) begin bad++; $display("FAIL be_idle got v=%b b=%b exp 0/0", valid_a, busy_a); end
    endtask

    task automatic test_timeout();
        ready_a = 1'b0;
        start_a = 1'b1; @(negedge clk); start_a = 1'b0;
        total++; if (valid_a !== 1'b1 || addr_a !== 32'h0 || err_a !== 1'b0) begin bad++; $display("FAIL to_start got v=%b a=%h e=%b", valid_a, addr_a, err_a); end
        repeat (15) @(negedge clk);
        total++; if (valid_a !== 1'b1 || addr_a !== 32'h0 || wdata_a !== WORDS[0] || done_a !== 1'b0) begin bad++; $display("FAIL to_hold got v=%b a=%h d=%h done=%b", valid_a, addr_a, wdata_a, done_a); end
        @(negedge clk);
        total++; if (valid_a !== 1'b0 || done_a !== 1'b1) begin bad++; $display("FAIL to_drop got v=%b d=%b exp 0/1", valid_a, done_a); end
        total++; if (err_a !== 1'b1 || code_a !== 2'd3 || idx_a !== 4'd0) begin bad++; $display("FAIL to_code got=%b/%0d/%0d exp=1/3/0", err_a, code_a, idx_a); end
        ready_a = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_busy_reset();
        total++; if (err_a !== 1'b1) begin bad++; $display("FAIL sticky_err got=%b exp=1", err_a); end
        start_a = 1'b1; @(negedge clk); start_a = 1'b0;
        total++; if (err_a !== 1'b0 || code_a !== 2'd0 || addr_a !== 32'h0 || valid_a !== 1'b1) begin bad++; $display("FAIL br_start got e=%b c=%0d a=%h v=%b", err_a, code_a, addr_a, valid_a); end
        repeat (2) @(negedge clk);
        start_a = 1'b1; @(negedge clk); start_a = 1'b0;
        total++; if (valid_a !== 1'b0 || busy_a !== 1'b1) begin bad++; $display("FAIL br_ignore got v=%b b=%b exp 0/1", valid_a, busy_a); end
        @(negedge clk);
        total++; if (valid_a !== 1'b1 || addr_a !== 32'h8) begin bad++; $display("FAIL br_k2 got v=%b a=%h exp 1/8", valid_a, addr_a); end
        repeat (4) @(negedge clk);
        total++; if (valid_a !== 1'b1 || addr_a !== 32'h10) begin bad++; $display("FAIL br_k4 got v=%b a=%h exp 1/10", valid_a, addr_a); end
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        total++; if (valid_a !== 1'b0 || busy_a !== 1'b0 || done_a !== 1'b0 || addr_a !== 32'h0) begin bad++; $display("FAIL br_rst got v=%b b=%b d=%b a=%h", valid_a, busy_a, done_a, addr_a); end
        start_a = 1'b1; @(negedge clk); start_a = 1'b0;
        total++; if (valid_a !== 1'b1 || addr_a !== 32'h0 || wdata_a !== WORDS[0] || err_a !== 1'b0) begin bad++; $display("FAIL br_restart got v=%b a=%h d=%h e=%b", valid_a, addr_a, wdata_a, err_a); end
        repeat (19) @(negedge clk);
        total++; if (done_a !== 1'b1 || err_a !== 1'b0) begin bad++; $display("FAIL br_done got d=%b e=%b exp 1/0", done_a, err_a); end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        start_a = 1'b0; ready_a = 1'b1; error_a = 1'b0; rdata_a = 32'h0;
        start_b = 1'b0; ready_b = 1'b1; error_b = 1'b0; zero_rd = 1'b0;
        for (int i = 0; i < 10; i++) cfg[32*i +: 32] = WORDS[i];
        @(negedge clk);
        test_reset();
        test_write_seq();
        test_verify();
        test_mismatch();
        test_bus_error();
        test_timeout();
        test_busy_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/hyperbus_cfg_loader.md
# hyperbus_cfg_loader

Boot-time REG_BUS initiator that programs the hyperbus configuration register file: on a start pulse it writes every configuration word (latency, recovery, CS-max, RWDS delay, variable-latency check, per-CS address map) over REG_BUS, optionally reads each word back and compares it, and reports completion or the first failure. It sits between the SoC boot/control logic and the hyperbus configuration slave, so the PHY is configured without CPU intervention.

## Interface
- NR_CS, 2, number of chip selects; sets NUM_REG = 6 + 2*NR_CS
- VERIFY, 1, 1 = read back and compare each word after writing it
- TIMEOUT, 256, max cycles a request may wait for reg_ready_i; 0 disables the timeout
- BASE_ADDR, 32'h0, byte address of config register 0

- clk_i  in  1  clock
- rst_i  in  1  reset; one clock, synchronous, active-high (fixed)
- start_i  in  1  start pulse; ignored while busy_o
- cfg_vals_i  in  32*NUM_REG  word k at [32k+31:32k]; must stay stable while busy_o
- reg_addr_o  out  32  BASE_ADDR + 4*k
- reg_write_o  out  1  1 = write, 0 = read
- reg_wdata_o  out  32  word k
- reg_wstrb_o  out  4  always 4'hF
- reg_valid_o  out  1  request valid
- reg_ready_i  in  1  responder accepts or completes
- reg_rdata_i  in  32  read data, valid in the handshake cycle
- reg_error_i  in  1  responder error, valid in the handshake cycle
- busy_o  out  1  sequence in progress
- done_o  out  1  one-cycle pulse at the end of the sequence (pass or fail)
- err_o  out  1  sticky failure flag; cleared by the next accepted start
- err_code_o  out  2  0 none, 1 bus error, 2 readback mismatch, 3 timeout
- err_idx_o  out  $clog2(NUM_REG)  index of the failing word

## Operation
- States: IDLE, WR, RD, NEXT, DONE.
- IDLE:
  - start_i accepted → index k=0, error outputs cleared, state WR.
- WR:
  - Drives reg_valid_o=1, reg_write_o=1, address for k, wdata = word k.
  - The handshake is valid & ready.
  - On handshake with reg_error_i=1: failure, code 1.
  - Otherwise go to RD if VERIFY, else to NEXT (or to DONE if k = NUM_REG-1).
- RD:
  - Same address, reg_write_o=0.
  - On handshake: reg_error_i gives code 1.
  - Otherwise compare (reg_rdata_i & M[k]) against (word k & M[k]); a difference gives code 2.
  - On pass, go to NEXT (or to DONE if k is last).
- Readback masks M[k]:
  - k0: 0xF; k1: 0xF; k2: 0xFF; k3: 0xF; k4: 0x7.
  - k5 and every address-map word: 0xFFFFFFFF.
- NEXT: one cycle with reg_valid_o=0; k increments; state WR.
- Failure:
  - Set err_o, err_code_o and err_idx_o = k, then go to DONE.
  - No further transfers are issued (abort on first error).
- DONE: done_o=1 for one cycle, then IDLE.
- busy_o = (state != IDLE).
- start_i in any state other than IDLE is ignored.

## Timing
- Reset values: reg_valid_o=0, reg_write_o=0, reg_addr_o=BASE_ADDR, reg_wdata_o=0, busy_o=0, done_o=0, err_o=0, err_code_o=0, err_idx_o=0; state IDLE.
- All outputs are registered. start_i sampled in cycle t gives reg_valid_o=1 in cycle t+1.
- Request hold: addr, write and wdata stay constant while valid & !ready. reg_valid_o never drops before the handshake, except on timeout or reset.
- Timeout counter:
  - Cleared on each new request; counts cycles of valid & !ready.
  - When it reaches TIMEOUT, reg_valid_o drops in the next cycle and the failure is code 3.
  - A handshake in the same cycle as the final count wins (no timeout).
- Cycle count with ready tied to 1:
  - VERIFY=0: 2 cycles per word, last word 1 cycle.
  - VERIFY=1: 3 cycles per word, last word 2 cycles.
- Reset mid-sequence: at the reset edge all outputs return to reset values. The request is abandoned and no done_o pulse is produced. A new start restarts at k=0.

## Test plan
- Reset, then NR_CS=2, VERIFY=0, ready=1, start at cycle 0:
  - Writes go to 0x00..0x24 with wdata = cfg_vals_i words, reg_valid_o high in cycles 1,3,…,19.
  - done_o in cycle 20, err_o=0.
- VERIFY=1, masking responder:
  - Word 4 written as 0x12345676 reads back as 0x6: passes.
  - All 10 words verified, done_o with err_code_o=0.
- Mismatch:
  - Word 2 = 665 (0x299) and the responder returns 0x00000000.
  - Result: err_code_o=2, err_idx_o=2, no request issued after the k=2 read.
- Bus error: reg_error_i=1 on the k=7 write handshake → err_code_o=1, err_idx_o=7, done_o the next cycle.
- Timeout: TIMEOUT=16, ready stuck at 0 → reg_valid_o low after 16 waiting cycles, err_code_o=3, err_idx_o=0.
- Busy and reset behaviour:
  - start_i pulsed while busy: no effect.
  - rst_i asserted during the k=4 write: reg_valid_o=0 and busy_o=0 after the edge.
  - A following start begins at address 0x00 with err_o cleared.
